// File: rtl/wb_stage.sv
// Write-back stage: drives the ID register-file write port, owns the HALT state
// machine and the saturating per-class retired-instruction counters.
module wb_stage #(
    parameter int ADDR_LINE = 5,
    parameter int D_SIZE    = 32,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_f_mem,
    input  logic [5:0]           opcode_f_mem,
    input  logic [ADDR_LINE-1:0] dest_f_mem,
    input  logic [D_SIZE-1:0]    alu_result_f_mem,
    input  logic [D_SIZE-1:0]    load_data_f_mem,
    output logic                 w_2_id,
    output logic [ADDR_LINE-1:0] addr_2_id,
    output logic [D_SIZE-1:0]    write_data_2_id,
    output logic                 halted,
    output logic                 err_illegal,
    output logic [CNT_W-1:0]     cnt_total,
    output logic [CNT_W-1:0]     cnt_arith,
    output logic [CNT_W-1:0]     cnt_logic,
    output logic [CNT_W-1:0]     cnt_mem,
    output logic [CNT_W-1:0]     cnt_ctrl
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    localparam logic [5:0] OP_LOGIC_LO = 6'h06;
    localparam logic [5:0] OP_LDW      = 6'h0C;
    localparam logic [5:0] OP_STW      = 6'h0D;
    localparam logic [5:0] OP_HALT     = 6'h11;

    state_t               state_q, state_d;
    logic                 w_q, w_d;
    logic [ADDR_LINE-1:0] addr_q, addr_d;
    logic [D_SIZE-1:0]    data_q, data_d;
    logic                 err_q, err_d;
    logic [CNT_W-1:0]     cnt_total_q, cnt_total_d;
    logic [CNT_W-1:0]     cnt_arith_q, cnt_arith_d;
    logic [CNT_W-1:0]     cnt_logic_q, cnt_logic_d;
    logic [CNT_W-1:0]     cnt_mem_q, cnt_mem_d;
    logic [CNT_W-1:0]     cnt_ctrl_q, cnt_ctrl_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    always_comb begin
        state_d     = state_q;
        w_d         = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        err_d       = err_q;
        cnt_total_d = cnt_total_q;
        cnt_arith_d = cnt_arith_q;
        cnt_logic_d = cnt_logic_q;
        cnt_mem_d   = cnt_mem_q;
        cnt_ctrl_d  = cnt_ctrl_q;

        if (state_q == ST_RUN && valid_f_mem) begin
            if (opcode_f_mem > OP_HALT) begin
                err_d = 1'b1;
            end else begin
                cnt_total_d = sat_inc(cnt_total_q);
                if (opcode_f_mem < OP_LOGIC_LO) begin
                    cnt_arith_d = sat_inc(cnt_arith_q);
                end else if (opcode_f_mem < OP_LDW) begin
                    cnt_logic_d = sat_inc(cnt_logic_q);
                end else if (opcode_f_mem <= OP_STW) begin
                    cnt_mem_d = sat_inc(cnt_mem_q);
                end else if (opcode_f_mem < OP_HALT) begin
                    cnt_ctrl_d = sat_inc(cnt_ctrl_q);
                end else begin
                    state_d = ST_HALTED;
                end

                // r0 is hard-wired zero, so writes to it are suppressed but still counted.
                if (opcode_f_mem <= OP_LDW && dest_f_mem != '0) begin
                    w_d    = 1'b1;
                    addr_d = dest_f_mem;
                    data_d = (opcode_f_mem == OP_LDW) ? load_data_f_mem : alu_result_f_mem;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            w_q         <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            err_q       <= 1'b0;
            cnt_total_q <= '0;
            cnt_arith_q <= '0;
            cnt_logic_q <= '0;
            cnt_mem_q   <= '0;
            cnt_ctrl_q  <= '0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            err_q       <= err_d;
            cnt_total_q <= cnt_total_d;
            cnt_arith_q <= cnt_arith_d;
            cnt_logic_q <= cnt_logic_d;
            cnt_mem_q   <= cnt_mem_d;
            cnt_ctrl_q  <= cnt_ctrl_d;
        end
    end

    assign w_2_id          = w_q;
    assign addr_2_id       = addr_q;
    assign write_data_2_id = data_q;
    assign halted          = (state_q == ST_HALTED);
    assign err_illegal     = err_q;
    assign cnt_total       = cnt_total_q;
    assign cnt_arith       = cnt_arith_q;
    assign cnt_logic       = cnt_logic_q;
    assign cnt_mem         = cnt_mem_q;
    assign cnt_ctrl        = cnt_ctrl_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed and random retirement streams against a small
// reference model, plus a narrow-counter instance for saturation.
module tb_wb_stage;

    localparam int AL = 5;
    localparam int DS = 32;
    localparam int CW = 32;
    localparam int SW = 4;

    typedef struct packed {
        logic          w;
        logic [AL-1:0] addr;
        logic [DS-1:0] data;
        logic          halted;
        logic          err;
        logic [CW-1:0] total;
        logic [CW-1:0] arith;
        logic [CW-1:0] logic_c;
        logic [CW-1:0] mem;
        logic [CW-1:0] ctrl;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          valid;
    logic [5:0]    opcode;
    logic [AL-1:0] dest;
    logic [DS-1:0] alu, load;
    logic          w_2_id, halted, err_illegal;
    logic [AL-1:0] addr_2_id;
    logic [DS-1:0] write_data_2_id;
    logic [CW-1:0] cnt_total, cnt_arith, cnt_logic, cnt_mem, cnt_ctrl;

    logic          s_reset, s_valid;
    logic [5:0]    s_opcode;
    logic [AL-1:0] s_dest;
    logic [DS-1:0] s_alu, s_load;
    logic          s_w, s_halted, s_err;
    logic [AL-1:0] s_addr;
    logic [DS-1:0] s_data;
    logic [SW-1:0] s_total, s_arith, s_logic, s_mem, s_ctrl;

    exp_t          exp_q[$];
    logic [SW-1:0] sat_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    exp_t m;

    always #5 clk = ~clk;

    wb_stage #(.ADDR_LINE(AL), .D_SIZE(DS), .CNT_W(CW)) u_dut (
        .clk(clk), .reset(reset), .valid_f_mem(valid), .opcode_f_mem(opcode),
        .dest_f_mem(dest), .alu_result_f_mem(alu), .load_data_f_mem(load),
        .w_2_id(w_2_id), .addr_2_id(addr_2_id), .write_data_2_id(write_data_2_id),
        .halted(halted), .err_illegal(err_illegal), .cnt_total(cnt_total),
        .cnt_arith(cnt_arith), .cnt_logic(cnt_logic), .cnt_mem(cnt_mem), .cnt_ctrl(cnt_ctrl)
    );

    wb_stage #(.ADDR_LINE(AL), .D_SIZE(DS), .CNT_W(SW)) u_sat (
        .clk(clk), .reset(s_reset), .valid_f_mem(s_valid), .opcode_f_mem(s_opcode),
        .dest_f_mem(s_dest), .alu_result_f_mem(s_alu), .load_data_f_mem(s_load),
        .w_2_id(s_w), .addr_2_id(s_addr), .write_data_2_id(s_data),
        .halted(s_halted), .err_illegal(s_err), .cnt_total(s_total),
        .cnt_arith(s_arith), .cnt_logic(s_logic), .cnt_mem(s_mem), .cnt_ctrl(s_ctrl)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] inc(input logic [CW-1:0] c);
        return (c == {CW{1'b1}}) ? c : c + 32'd1;
    endfunction

    // Advance the reference model by one sampled cycle.
    task automatic model_step(input logic r, input logic v, input logic [5:0] op,
                              input logic [AL-1:0] d, input logic [DS-1:0] a,
                              input logic [DS-1:0] l);
        if (r) begin
            m = '0;
        end else begin
            m.w = 1'b0;
            if (v && !m.halted) begin
                if (op >= 6'h12) begin
                    m.err = 1'b1;
                end else begin
                    m.total = inc(m.total);
                    case (op)
                        6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05: m.arith = inc(m.arith);
                        6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B: m.logic_c = inc(m.logic_c);
                        6'h0C, 6'h0D:                             m.mem = inc(m.mem);
                        6'h0E, 6'h0F, 6'h10:                      m.ctrl = inc(m.ctrl);
                        default:                                  m.halted = 1'b1;
                    endcase
                    if (d != 0 && op <= 6'h0B) begin
                        m.w = 1'b1; m.addr = d; m.data = a;
                    end else if (d != 0 && op == 6'h0C) begin
                        m.w = 1'b1; m.addr = d; m.data = l;
                    end
                end
            end
        end
    endtask

    task automatic compare_main(input string tag);
        exp_t e;
        e = exp_q.pop_front();
        chk({tag, ".w"},      w_2_id, e.w);
        chk({tag, ".addr"},   addr_2_id, e.addr);
        chk({tag, ".data"},   write_data_2_id, e.data);
        chk({tag, ".halted"}, halted, e.halted);
        chk({tag, ".err"},    err_illegal, e.err);
        chk({tag, ".total"},  cnt_total, e.total);
        chk({tag, ".arith"},  cnt_arith, e.arith);
        chk({tag, ".logic"},  cnt_logic, e.logic_c);
        chk({tag, ".mem"},    cnt_mem, e.mem);
        chk({tag, ".ctrl"},   cnt_ctrl, e.ctrl);
    endtask

    // Drive one cycle on the main DUT, push expectation, then check after the edge.
    task automatic step(input string tag, input logic r, input logic v, input logic [5:0] op,
                        input logic [AL-1:0] d, input logic [DS-1:0] a, input logic [DS-1:0] l);
        @(negedge clk);
        reset = r; valid = v; opcode = op; dest = d; alu = a; load = l;
        model_step(r, v, op, d, a, l);
        exp_q.push_back(m);
        @(posedge clk);
        #1;
        compare_main(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 6'h00, '0, '0, '0);
    endtask

    initial begin
        reset = 1'b1; valid = 1'b0; opcode = '0; dest = '0; alu = '0; load = '0;
        s_reset = 1'b1; s_valid = 1'b0; s_opcode = '0; s_dest = '0; s_alu = '0; s_load = '0;
        m = '0;

        // Reset held two cycles with a valid ADD present, then one clean cycle
        step("rst0", 1'b1, 1'b1, 6'h00, 5'd3, 32'h1234, 32'h0);
        step("rst1", 1'b1, 1'b1, 6'h00, 5'd3, 32'h1234, 32'h0);
        idle("rst_rel");
        chk("rst_rel_total_zero", cnt_total, 0);

        // ADD then idle
        step("add", 1'b0, 1'b1, 6'h00, 5'd3, 32'h0000_1234, 32'h0);
        chk("add_data_const", write_data_2_id, 32'h0000_1234);
        chk("add_arith_const", cnt_arith, 1);
        idle("add_idle");
        chk("add_idle_w_const", w_2_id, 0);

        // LDW selects load data, STW does not write
        step("ldw", 1'b0, 1'b1, 6'h0C, 5'd7, 32'h40, 32'hDEAD_BEEF);
        chk("ldw_data_const", write_data_2_id, 32'hDEAD_BEEF);
        step("stw", 1'b0, 1'b1, 6'h0D, 5'd7, 32'h44, 32'h1111_2222);
        chk("stw_mem_const", cnt_mem, 2);

        // r0 write suppression and illegal opcode
        step("rst_a", 1'b1, 1'b0, 6'h00, '0, '0, '0);
        step("addi_r0", 1'b0, 1'b1, 6'h01, 5'd0, 32'h5, 32'h0);
        chk("addi_r0_w_const", w_2_id, 0);
        step("illegal", 1'b0, 1'b1, 6'h3F, 5'd9, 32'h77, 32'h0);
        chk("illegal_err_const", err_illegal, 1);
        chk("illegal_total_const", cnt_total, 1);
        step("illegal_lo", 1'b0, 1'b1, 6'h12, 5'd9, 32'h78, 32'h0);
        idle("err_sticky");

        // Random legal/illegal stream, including the class boundaries
        step("rst_b", 1'b1, 1'b0, 6'h00, '0, '0, '0);
        for (int i = 0; i < 40; i++) begin
            logic [5:0] op;
            op = (i % 8 == 7) ? 6'($urandom_range(6'h12, 6'h3F)) : 6'($urandom_range(0, 6'h10));
            step("rand", 1'b0, 1'($urandom_range(0, 1)) | (i < 4), op,
                 5'($urandom_range(0, 31)), $urandom, $urandom);
        end

        // Reset mid-stream drops the in-flight instruction
        step("mid_rst", 1'b1, 1'b1, 6'h00, 5'd5, 32'hAAAA, 32'h0);
        chk("mid_rst_w_const", w_2_id, 0);

        // HALT freezes the stage until reset
        step("halt", 1'b0, 1'b1, 6'h11, 5'd2, 32'h0, 32'h0);
        chk("halt_flag_const", halted, 1);
        step("post_halt_add", 1'b0, 1'b1, 6'h00, 5'd4, 32'h99, 32'h0);
        step("post_halt_ill", 1'b0, 1'b1, 6'h3F, 5'd4, 32'h99, 32'h0);
        chk("post_halt_total_const", cnt_total, 1);
        step("halt_rst", 1'b1, 1'b1, 6'h00, 5'd4, 32'h99, 32'h0);
        step("resume_add", 1'b0, 1'b1, 6'h00, 5'd4, 32'hBEEF, 32'h0);
        chk("resume_w_const", w_2_id, 1);
        idle("final_idle");

        // Saturation on the 4-bit counter instance: 20 back-to-back ORs
        @(negedge clk);
        s_reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            s_valid = 1'b1; s_opcode = 6'h06; s_dest = 5'd1; s_alu = 32'(k);
            sat_q.push_back((k > 15) ? 4'd15 : 4'(k));
            @(posedge clk);
            #1;
            begin
                logic [SW-1:0] e;
                e = sat_q.pop_front();
                chk("sat_logic", s_logic, e);
                chk("sat_total", s_total, e);
                chk("sat_w", s_w, 1);
                chk("sat_data", s_data, 32'(k));
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("sat_idle_w", s_w, 0);
        chk("sat_arith", s_arith, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
